// File: rtl/pulse_burst_pkg.sv
// Shared types and width helpers for the pulse burst analyzer.
// State encoding is exported so benches and debug logic can decode dbg_state.
package pulse_burst_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pb_state_e;

    // Bits needed to hold any value in 0..max_val (never less than one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pulse_burst_analyzer_edge_detect.sv
// One-register edge detector. The reset/clear value of the history register
// is a parameter so a line that is already high when reset is released is not
// mistaken for a rising edge.
module edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    // History of the input; clear returns it to the reset value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= RESET_VAL;
        end else if (i_clr) begin
            r_prev <= RESET_VAL;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;
    assign o_fall = ~i_sig & r_prev;

endmodule

// File: rtl/pulse_burst_analyzer.sv
// Burst monitor for a pulse train: measures high width, inter-pulse gap and
// pulse count, and closes a burst after IDLE_TIMEOUT consecutive low samples.
// Optional feature macro: PULSE_BURST_CHECK_EN compiles in the uniformity and
// saturation checks that drive err; without it err is tied low.
// Output protocol: burst_done is a one-cycle valid strobe with no ready; the
// result registers (pulse_cnt, err) hold until the next strobe or clr.
// Assumes IDLE_TIMEOUT <= MAX_WIDTH so the gap counter fits the width field.
module pulse_burst_analyzer
    import pulse_burst_pkg::*;
#(
    parameter int MAX_WIDTH    = 64,
    parameter int IDLE_TIMEOUT = 8,
    parameter int MAX_PULSES   = 255,
    localparam int WW = cnt_w(MAX_WIDTH),
    localparam int CW = cnt_w(MAX_PULSES)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          pulse_in,
    input  logic          clr,
    output logic          busy,
    output logic          burst_done,
    output logic [CW-1:0] pulse_cnt,
    output logic [WW-1:0] high_width,
    output logic [WW-1:0] low_width,
    output logic          err,
    output pb_state_e     dbg_state
);

    localparam logic [WW-1:0] MAX_W    = WW'(MAX_WIDTH);
    localparam logic [WW-1:0] LAST_LOW = WW'(IDLE_TIMEOUT - 1);
    localparam logic [CW-1:0] MAX_P    = CW'(MAX_PULSES);

    logic w_rise;
    logic w_fall;

    pb_state_e     r_state;
    logic          r_busy;
    logic          r_burst_done;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_pulse_cnt;
    logic [WW-1:0] r_hcnt;
    logic [WW-1:0] r_lcnt;
    logic [WW-1:0] r_high_width;
    logic [WW-1:0] r_low_width;
`ifdef PULSE_BURST_CHECK_EN
    logic          r_first_high;
    logic          r_first_gap;
    logic [WW-1:0] r_ref_high;
    logic [WW-1:0] r_ref_gap;
    logic          r_err_flag;
    logic          r_err;
`endif

    edge_detect #(.RESET_VAL(1'b1)) u_edge (
        .i_clk   (clk),
        .i_rst_n (rstn),
        .i_clr   (clr),
        .i_sig   (pulse_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Burst FSM with its width/gap/pulse counters and registered results.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_burst_done <= 1'b0;
            r_count      <= '0;
            r_pulse_cnt  <= '0;
            r_hcnt       <= '0;
            r_lcnt       <= '0;
            r_high_width <= '0;
            r_low_width  <= '0;
`ifdef PULSE_BURST_CHECK_EN
            r_first_high <= 1'b0;
            r_first_gap  <= 1'b0;
            r_ref_high   <= '0;
            r_ref_gap    <= '0;
            r_err_flag   <= 1'b0;
            r_err        <= 1'b0;
`endif
        end else if (clr) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_burst_done <= 1'b0;
            r_count      <= '0;
            r_pulse_cnt  <= '0;
            r_hcnt       <= '0;
            r_lcnt       <= '0;
            r_high_width <= '0;
            r_low_width  <= '0;
`ifdef PULSE_BURST_CHECK_EN
            r_first_high <= 1'b0;
            r_first_gap  <= 1'b0;
            r_ref_high   <= '0;
            r_ref_gap    <= '0;
            r_err_flag   <= 1'b0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_burst_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= HIGH;
                        r_busy  <= 1'b1;
                        r_hcnt  <= WW'(1);
                        r_count <= CW'(1);
`ifdef PULSE_BURST_CHECK_EN
                        r_first_high <= 1'b1;
                        r_first_gap  <= 1'b1;
                        r_err_flag   <= 1'b0;
`endif
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        r_high_width <= r_hcnt;
                        r_lcnt       <= WW'(1);
                        r_state      <= LOW;
`ifdef PULSE_BURST_CHECK_EN
                        r_first_high <= 1'b0;
                        if (r_first_high) begin
                            r_ref_high <= r_hcnt;
                        end else if (r_hcnt != r_ref_high) begin
                            r_err_flag <= 1'b1;
                        end
`endif
                    end else if (r_hcnt == MAX_W) begin
`ifdef PULSE_BURST_CHECK_EN
                        r_err_flag <= 1'b1;
`endif
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        // A rise sample is not a low sample, so it always beats the timeout.
                        r_low_width <= r_lcnt;
                        r_hcnt      <= WW'(1);
                        r_state     <= HIGH;
                        if (r_count != MAX_P) begin
                            r_count <= r_count + 1'b1;
                        end
`ifdef PULSE_BURST_CHECK_EN
                        r_first_gap <= 1'b0;
                        if (r_first_gap) begin
                            r_ref_gap <= r_lcnt;
                        end else if (r_lcnt != r_ref_gap) begin
                            r_err_flag <= 1'b1;
                        end
                        if (r_count == MAX_P) begin
                            r_err_flag <= 1'b1;
                        end
`endif
                    end else if (r_lcnt == LAST_LOW) begin
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_burst_done <= 1'b1;
                        r_pulse_cnt  <= r_count;
`ifdef PULSE_BURST_CHECK_EN
                        r_err        <= r_err_flag;
`endif
                    end else begin
                        r_lcnt <= r_lcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign burst_done = r_burst_done;
    assign pulse_cnt  = r_pulse_cnt;
    assign high_width = r_high_width;
    assign low_width  = r_low_width;
    assign dbg_state  = r_state;
`ifdef PULSE_BURST_CHECK_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_burst_analyzer.sv
// Directed bench for pulse_burst_analyzer with default parameters.
// Table of burst shapes with hand-computed results, plus hand-written
// sequences for reset release, async reset, back-to-back bursts and clr.
module tb_pulse_burst_analyzer;
  import pulse_burst_pkg::*;

  localparam int IDLE_TIMEOUT = 8;
`ifdef PULSE_BURST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic pulse_in = 1'b1;
  logic clr = 1'b0;
  logic busy, burst_done, err;
  logic [7:0] pulse_cnt;
  logic [6:0] high_width, low_width;
  pb_state_e dbg_state;

  always #5 clk = ~clk;

  pulse_burst_analyzer dut (
    .clk        (clk),
    .rstn       (rstn),
    .pulse_in   (pulse_in),
    .clr        (clr),
    .busy       (busy),
    .burst_done (burst_done),
    .pulse_cnt  (pulse_cnt),
    .high_width (high_width),
    .low_width  (low_width),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    string name;
    int    h[3];
    int    l[2];
    int    n_pulse;
    int    exp_cnt;
    int    exp_hw;
    int    exp_lw;
    bit    exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: present one sample, let the DUT register it, then settle
  task automatic step(input logic v);
    pulse_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dut();
    clr = 1'b1;
    step(1'b0);
    clr = 1'b0;
  endtask

  function automatic vec_t mk(input string nm, input int h0, input int h1, input int h2,
                              input int l0, input int l1, input int np, input int c,
                              input int hw, input int lw, input bit e);
    vec_t v;
    v.name = nm;
    v.h[0] = h0; v.h[1] = h1; v.h[2] = h2;
    v.l[0] = l0; v.l[1] = l1;
    v.n_pulse = np;
    v.exp_cnt = c;
    v.exp_hw = hw;
    v.exp_lw = lw;
    v.exp_err = e;
    return v;
  endfunction

  // drive lows until burst_done; returns the number of low samples needed
  task automatic wait_done(input int last_high, input string nm, output int done_at);
    done_at = 0;
    for (int n = 1; n <= 30; n++) begin
      step(1'b0);
      if (n == 1) check({nm, " hw_after_fall"}, high_width, last_high > 64 ? 64 : last_high);
      if (burst_done) begin
        done_at = n;
        break;
      end
    end
    check({nm, " done_latency"}, done_at, IDLE_TIMEOUT);
  endtask

  task automatic run_vec(input vec_t v);
    int done_at;
    clear_dut();
    step(1'b0);
    step(1'b0);
    check({v.name, " busy_idle"}, busy, 0);
    for (int p = 0; p < v.n_pulse; p++) begin
      for (int c = 0; c < v.h[p]; c++) begin
        step(1'b1);
        if (p == 0 && c == 0) check({v.name, " busy_rise"}, busy, 1);
        if (p > 0 && c == 0) check({v.name, " lw_after_rise"}, low_width, v.l[p-1]);
      end
      if (p < v.n_pulse - 1) begin
        for (int c = 0; c < v.l[p]; c++) begin
          step(1'b0);
          if (c == 0) check({v.name, " hw_mid"}, high_width, v.h[p]);
        end
      end
    end
    wait_done(v.h[v.n_pulse-1], v.name, done_at);
    check({v.name, " busy_fall"}, busy, 0);
    check({v.name, " pulse_cnt"}, pulse_cnt, v.exp_cnt);
    check({v.name, " high_width"}, high_width, v.exp_hw);
    check({v.name, " low_width"}, low_width, v.exp_lw);
    check({v.name, " err"}, err, v.exp_err & CHK);
    step(1'b0);
    check({v.name, " done_one_cycle"}, burst_done, 0);
    check({v.name, " pulse_cnt_hold"}, pulse_cnt, v.exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int done_at;
    vecs[0] = mk("counter",    4,   4, 0, 4, 0, 2, 2, 4,  4, 1'b0);
    vecs[1] = mk("single",     1,   0, 0, 0, 0, 1, 1, 1,  0, 1'b0);
    vecs[2] = mk("nonuniform", 4,   3, 0, 4, 0, 2, 2, 3,  4, 1'b1);
    vecs[3] = mk("gap_to_m1",  2,   2, 0, 7, 0, 2, 2, 2,  7, 1'b0);
    vecs[4] = mk("three",      3,   3, 3, 2, 2, 3, 3, 3,  2, 1'b0);
    vecs[5] = mk("gap_diff",   2,   2, 2, 3, 5, 3, 3, 2,  5, 1'b1);
    vecs[6] = mk("h64",        64,  0, 0, 0, 0, 1, 1, 64, 0, 1'b0);
    vecs[7] = mk("h100_sat",   100, 0, 0, 0, 0, 1, 1, 64, 0, 1'b1);

    // reset state, line held high through reset release
    pulse_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst burst_done", burst_done, 0);
    check("rst pulse_cnt", pulse_cnt, 0);
    check("rst high_width", high_width, 0);
    check("rst low_width", low_width, 0);
    check("rst err", err, 0);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      if (busy || burst_done) seen++;
    end
    check("high_at_release no_start", seen, 0);
    step(1'b0);
    check("high_at_release still_idle", busy, 0);

    // a full burst so the outputs are non-zero, then reset mid-HIGH
    for (int i = 0; i < 4; i++) step(1'b1);
    check("pre_reset busy", busy, 1);
    for (int i = 0; i < 4; i++) step(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1);
    wait_done(4, "pre_reset", done_at);
    check("pre_reset pulse_cnt", pulse_cnt, 2);
    step(1'b1);
    step(1'b1);
    check("mid_high busy", busy, 1);
    rstn = 1'b0;
    #1;
    check("async_rst busy", busy, 0);
    check("async_rst pulse_cnt", pulse_cnt, 0);
    check("async_rst high_width", high_width, 0);
    check("async_rst low_width", low_width, 0);
    check("async_rst state", dbg_state, IDLE);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0);
      if (burst_done) seen++;
    end
    check("async_rst no_done", seen, 0);

    // table-driven bursts
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // gap of exactly IDLE_TIMEOUT: two bursts, second rise while burst_done is high
    clear_dut();
    step(1'b0);
    step(1'b1);
    step(1'b1);
    for (int n = 1; n <= IDLE_TIMEOUT; n++) begin
      step(1'b0);
      check($sformatf("gap_to done_at_%0d", n), burst_done, (n == IDLE_TIMEOUT) ? 1 : 0);
    end
    check("gap_to first pulse_cnt", pulse_cnt, 1);
    step(1'b1);
    check("gap_to done_cleared", burst_done, 0);
    check("gap_to restart busy", busy, 1);
    check("gap_to cnt_hold", pulse_cnt, 1);
    step(1'b1);
    wait_done(2, "gap_to second", done_at);
    check("gap_to second pulse_cnt", pulse_cnt, 1);
    check("gap_to low_width", low_width, 0);

    // clr mid-burst after a completed burst
    run_vec(vecs[0]);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    check("clr pre busy", busy, 1);
    clr = 1'b1;
    step(1'b1);
    clr = 1'b0;
    check("clr busy", busy, 0);
    check("clr pulse_cnt", pulse_cnt, 0);
    check("clr high_width", high_width, 0);
    check("clr low_width", low_width, 0);
    check("clr err", err, 0);
    check("clr state", dbg_state, IDLE);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0);
      if (burst_done || busy) seen++;
    end
    check("clr no_done", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
